// File: rtl/multicycle_ctrl.sv
// Main control unit of a multicycle MIPS-style datapath: a Moore FSM whose
// strobes and mux selects depend on the current state alone.
module multicycle_ctrl #(
  parameter int MEM_WAIT = 1,
  parameter int STATE_W  = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         OPcode,
  input  logic [5:0]         funct,
  output logic               EscreveMem,
  output logic               EscrevePC,
  output logic               EscrevePCCondEQ,
  output logic               EscrevePCCondNE,
  output logic               RegDst,
  output logic               EscreveReg,
  output logic               IouD,
  output logic               EscreveIR,
  output logic               EscreveMDR,
  output logic               EscreveAluOut,
  output logic               OrigAALU,
  output logic [1:0]         OrigPC,
  output logic [1:0]         MemparaReg,
  output logic [1:0]         OrigBALU,
  output logic [1:0]         OpALU,
  output logic               Excecao,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [4:0] {
    MEM_READ    = 5'd0,
    ESPERA      = 5'd1,
    IR_WRITE    = 5'd2,
    DECOD       = 5'd3,
    CLASSE_R    = 5'd4,
    WRITE_RD    = 5'd5,
    REF_MEM     = 5'd6,
    LOAD        = 5'd7,
    STORE       = 5'd8,
    END_REF_MEM = 5'd9,
    BREAK       = 5'd10,
    NOP         = 5'd11,
    BEQ         = 5'd12,
    BNE         = 5'd13,
    LUI         = 5'd14,
    JUMP        = 5'd15,
    LOAD_ESPERA = 5'd16,
    ADDI        = 5'd17,
    ADDI_WR     = 5'd18,
    EXCECAO     = 5'd19
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0D;

  // Last count value of a memory wait; MEM_WAIT=1 makes each wait state one cycle.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  stateT      state;
  stateT      nextState;
  logic [3:0] waitCount;
  logic       inWait;
  logic       waitDone;

  assign inWait   = (state == ESPERA) || (state == LOAD_ESPERA);
  assign waitDone = (waitCount == WAIT_LAST);
  assign State    = STATE_W'(state);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MEM_READ;
      waitCount <= '0;
    end else begin
      state     <= nextState;
      // Counter starts at 0 on entry to a wait state and counts while it stays there.
      waitCount <= (inWait && (nextState == state)) ? waitCount + 4'd1 : '0;
    end
  end

  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = MEM_READ;
    case (state)
      MEM_READ:    nextState = ESPERA;
      ESPERA:      nextState = waitDone ? IR_WRITE : ESPERA;
      IR_WRITE:    nextState = DECOD;
      DECOD: begin
        case (OPcode)
          OP_RTYPE: begin
            if (funct == FN_BREAK)    nextState = BREAK;
            else if (funct == FN_NOP) nextState = NOP;
            else                      nextState = CLASSE_R;
          end
          OP_J:         nextState = JUMP;
          OP_BEQ:       nextState = BEQ;
          OP_BNE:       nextState = BNE;
          OP_ADDI:      nextState = ADDI;
          OP_LW, OP_SW: nextState = REF_MEM;
          OP_LUI:       nextState = LUI;
          default:      nextState = EXCECAO;
        endcase
      end
      CLASSE_R:    nextState = WRITE_RD;
      WRITE_RD:    nextState = MEM_READ;
      // IR is held, so only LW or SW can reach here.
      REF_MEM:     nextState = (OPcode == OP_SW) ? STORE : LOAD;
      LOAD:        nextState = LOAD_ESPERA;
      LOAD_ESPERA: nextState = waitDone ? END_REF_MEM : LOAD_ESPERA;
      END_REF_MEM: nextState = MEM_READ;
      ADDI:        nextState = ADDI_WR;
      ADDI_WR:     nextState = MEM_READ;
      BREAK:       nextState = BREAK;
      STORE, NOP, BEQ, BNE, LUI, JUMP, EXCECAO: nextState = MEM_READ;
      default:     nextState = MEM_READ;
    endcase
  end

  always_comb begin
    EscreveMem      = 1'b0;
    EscrevePC       = 1'b0;
    EscrevePCCondEQ = 1'b0;
    EscrevePCCondNE = 1'b0;
    RegDst          = 1'b0;
    EscreveReg      = 1'b0;
    IouD            = 1'b0;
    EscreveIR       = 1'b0;
    EscreveMDR      = 1'b0;
    EscreveAluOut   = 1'b0;
    OrigAALU        = 1'b0;
    OrigPC          = 2'b00;
    MemparaReg      = 2'b00;
    OrigBALU        = 2'b00;
    OpALU           = 2'b00;
    Excecao         = 1'b0;
    case (state)
      MEM_READ: begin
        EscrevePC = 1'b1;
        OrigBALU  = 2'b01;
      end
      IR_WRITE: begin
        EscreveIR     = 1'b1;
        OrigBALU      = 2'b11;
        EscreveAluOut = 1'b1;
      end
      CLASSE_R: begin
        OrigAALU      = 1'b1;
        OpALU         = 2'b10;
        EscreveAluOut = 1'b1;
      end
      WRITE_RD: begin
        RegDst     = 1'b1;
        EscreveReg = 1'b1;
        OpALU      = 2'b10;
      end
      REF_MEM, ADDI: begin
        OrigAALU      = 1'b1;
        OrigBALU      = 2'b10;
        EscreveAluOut = 1'b1;
      end
      LOAD, LOAD_ESPERA: begin
        IouD       = 1'b1;
        EscreveMDR = 1'b1;
      end
      STORE: begin
        IouD       = 1'b1;
        EscreveMem = 1'b1;
      end
      END_REF_MEM: begin
        EscreveReg = 1'b1;
        MemparaReg = 2'b01;
      end
      ADDI_WR: begin
        EscreveReg = 1'b1;
        MemparaReg = 2'b00;
      end
      BEQ: begin
        OrigAALU        = 1'b1;
        OpALU           = 2'b01;
        OrigPC          = 2'b01;
        EscrevePCCondEQ = 1'b1;
      end
      BNE: begin
        OrigAALU        = 1'b1;
        OpALU           = 2'b01;
        OrigPC          = 2'b01;
        EscrevePCCondNE = 1'b1;
      end
      LUI: begin
        EscreveReg = 1'b1;
        MemparaReg = 2'b10;
      end
      JUMP: begin
        EscrevePC = 1'b1;
        OrigPC    = 2'b10;
      end
      // Trap: redirect PC to the exception vector without touching registers or memory.
      EXCECAO: begin
        Excecao   = 1'b1;
        EscrevePC = 1'b1;
        OrigPC    = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MEM_WAIT=1 and 3), expected
// state/control trace queued per instruction and compared every cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem, pc, eq, ne, regDst, wreg, iouD, ir, mdr, aluOut, origA, exc;
    logic [1:0] origPC, memReg, origB, opAlu;
  } ctrlT;

  typedef struct packed {
    logic [5:0] st;
    ctrlT       ctl;
  } expT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Index 0: MEM_WAIT=1 instance, index 1: MEM_WAIT=3 instance.
  logic [1:0]       rst;
  logic [1:0][5:0]  op, fn;
  logic [1:0]       eMem, ePC, eEq, eNe, rDst, eReg, iouD, eIR, eMDR, eAlu, oA, exc;
  logic [1:0][1:0]  oPC, mReg, oB, opAlu;
  logic [1:0][5:0]  st;

  multicycle_ctrl #(.MEM_WAIT(1), .STATE_W(6)) dut1 (
    .clock(clock), .reset(rst[0]), .OPcode(op[0]), .funct(fn[0]),
    .EscreveMem(eMem[0]), .EscrevePC(ePC[0]), .EscrevePCCondEQ(eEq[0]),
    .EscrevePCCondNE(eNe[0]), .RegDst(rDst[0]), .EscreveReg(eReg[0]), .IouD(iouD[0]),
    .EscreveIR(eIR[0]), .EscreveMDR(eMDR[0]), .EscreveAluOut(eAlu[0]), .OrigAALU(oA[0]),
    .OrigPC(oPC[0]), .MemparaReg(mReg[0]), .OrigBALU(oB[0]), .OpALU(opAlu[0]),
    .Excecao(exc[0]), .State(st[0])
  );

  multicycle_ctrl #(.MEM_WAIT(3), .STATE_W(6)) dut3 (
    .clock(clock), .reset(rst[1]), .OPcode(op[1]), .funct(fn[1]),
    .EscreveMem(eMem[1]), .EscrevePC(ePC[1]), .EscrevePCCondEQ(eEq[1]),
    .EscrevePCCondNE(eNe[1]), .RegDst(rDst[1]), .EscreveReg(eReg[1]), .IouD(iouD[1]),
    .EscreveIR(eIR[1]), .EscreveMDR(eMDR[1]), .EscreveAluOut(eAlu[1]), .OrigAALU(oA[1]),
    .OrigPC(oPC[1]), .MemparaReg(mReg[1]), .OrigBALU(oB[1]), .OpALU(opAlu[1]),
    .Excecao(exc[1]), .State(st[1])
  );

  int  errors = 0;
  int  checks = 0;
  int  cyc    = 0;
  expT sb[$];

  // Reference control word for each state code, from the state output table.
  function automatic ctrlT expCtrl(int s);
    ctrlT c;
    c = '0;
    case (s)
      0:      begin c.pc = 1; c.origB = 2'b01; end
      2:      begin c.ir = 1; c.origB = 2'b11; c.aluOut = 1; end
      4:      begin c.origA = 1; c.opAlu = 2'b10; c.aluOut = 1; end
      5:      begin c.regDst = 1; c.wreg = 1; c.opAlu = 2'b10; end
      6, 17:  begin c.origA = 1; c.origB = 2'b10; c.aluOut = 1; end
      7, 16:  begin c.iouD = 1; c.mdr = 1; end
      8:      begin c.iouD = 1; c.mem = 1; end
      9:      begin c.wreg = 1; c.memReg = 2'b01; end
      18:     begin c.wreg = 1; c.memReg = 2'b00; end
      12:     begin c.origA = 1; c.opAlu = 2'b01; c.origPC = 2'b01; c.eq = 1; end
      13:     begin c.origA = 1; c.opAlu = 2'b01; c.origPC = 2'b01; c.ne = 1; end
      14:     begin c.wreg = 1; c.memReg = 2'b10; end
      15:     begin c.pc = 1; c.origPC = 2'b10; end
      19:     begin c.exc = 1; c.pc = 1; c.origPC = 2'b11; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctrlT obsCtrl(int s);
    ctrlT c;
    c.mem = eMem[s]; c.pc = ePC[s]; c.eq = eEq[s]; c.ne = eNe[s];
    c.regDst = rDst[s]; c.wreg = eReg[s]; c.iouD = iouD[s]; c.ir = eIR[s];
    c.mdr = eMDR[s]; c.aluOut = eAlu[s]; c.origA = oA[s]; c.exc = exc[s];
    c.origPC = oPC[s]; c.memReg = mReg[s]; c.origB = oB[s]; c.opAlu = opAlu[s];
    return c;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push(int code);
    expT e;
    e.st  = 6'(code);
    e.ctl = expCtrl(code);
    sb.push_back(e);
  endtask

  task automatic pushFetch(int sel);
    int w;
    w = (sel == 0) ? 1 : 3;
    push(0);
    repeat (w) push(1);
    push(2);
    push(3);
  endtask

  // Expected state trace of one instruction, from fetch to its last state.
  task automatic pushInstr(int sel, logic [5:0] o, logic [5:0] f);
    int w;
    w = (sel == 0) ? 1 : 3;
    pushFetch(sel);
    case (o)
      6'h00: begin
        if (f == 6'h0D)      repeat (20) push(10);
        else if (f == 6'h00) push(11);
        else begin push(4); push(5); end
      end
      6'h02: push(15);
      6'h04: push(12);
      6'h05: push(13);
      6'h08: begin push(17); push(18); end
      6'h23: begin push(6); push(7); repeat (w) push(16); push(9); end
      6'h2B: begin push(6); push(8); end
      6'h0F: push(14);
      default: push(19);
    endcase
  endtask

  // Compares one queued entry per cycle; stops on the cycle of the last entry.
  task automatic drain(int sel);
    expT e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("d%0d cyc%0d state", sel, cyc), 32'(st[sel]), 32'(e.st));
      check($sformatf("d%0d cyc%0d ctrl st%0d", sel, cyc, e.st),
            32'(obsCtrl(sel)), 32'(e.ctl));
      if (sb.size() > 0) stepClk();
    end
  endtask

  task automatic runInstr(int sel, logic [5:0] o, logic [5:0] f);
    op[sel] = o;
    fn[sel] = f;
    pushInstr(sel, o, f);
    drain(sel);
    stepClk();
  endtask

  task automatic resetDut(int sel);
    rst[sel] = 1'b1;
    stepClk();
    rst[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 2'b11;
    op  = {6'h02, 6'h02};
    fn  = '0;
    stepClk();
    stepClk();
    rst = 2'b00;

    // MEM_WAIT=1: every opcode class, first entry covers the post-reset outputs.
    runInstr(0, 6'h00, 6'h20);
    runInstr(0, 6'h00, 6'h00);
    runInstr(0, 6'h02, 6'h00);
    runInstr(0, 6'h04, 6'h00);
    runInstr(0, 6'h05, 6'h00);
    runInstr(0, 6'h0F, 6'h00);
    runInstr(0, 6'h08, 6'h00);
    runInstr(0, 6'h2B, 6'h00);
    runInstr(0, 6'h23, 6'h00);
    runInstr(0, 6'h3F, 6'h00);
    runInstr(0, 6'h01, 6'h00);

    // BREAK holds for 20 checked cycles plus one more, then only reset leaves it.
    runInstr(0, 6'h00, 6'h0D);
    check("break hold", 32'(st[0]), 32'd10);
    check("break ctrl", 32'(obsCtrl(0)), 32'd0);
    op[0] = 6'h00;
    fn[0] = 6'h20;
    resetDut(0);
    runInstr(0, 6'h00, 6'h20);

    // MEM_WAIT=3 instance, started from a clean reset.
    resetDut(1);
    runInstr(1, 6'h23, 6'h00);
    runInstr(1, 6'h00, 6'h22);

    // Reset during the second LOAD_ESPERA cycle, then a full 3-cycle ESPERA.
    op[1] = 6'h23;
    fn[1] = 6'h00;
    pushFetch(1);
    push(6);
    push(7);
    push(16);
    push(16);
    drain(1);
    rst[1] = 1'b1;
    stepClk();
    rst[1] = 1'b0;
    runInstr(1, 6'h00, 6'h20);

    runInstr(1, 6'h2B, 6'h00);
    runInstr(1, 6'h08, 6'h00);
    runInstr(1, 6'h3F, 6'h00);
    runInstr(1, 6'h04, 6'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
